spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 106 ++++++++++
 tb/tb_spi_reg_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns 16-bit command/data frames into register read/write strobes
module spi_reg_bridge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    output logic [7:0] data_write,
    input  logic [7:0] data_read,
    output logic       frame_err
);
    typedef enum logic [2:0] {IDLE, CMD, WDATA, RREQ, RCAP, RDATA, DONE} state_t;
    state_t     r_state, w_next;
    logic [2:0] r_sclk, r_cs;
    logic [1:0] r_mosi, r_vld;
    logic       r_armed, r_write;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_tx, r_data_write;
    logic [5:0] r_addr;
    logic       w_mosi, w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_last, w_abort, w_start;
    assign w_mosi      = r_mosi[1];
    assign w_sclk_rise = r_sclk[1] & ~r_sclk[2];
    assign w_sclk_fall = ~r_sclk[1] & r_sclk[2];
    assign w_cs_rise   = r_cs[1] & ~r_cs[2];
    assign w_cs_fall   = ~r_cs[1] & r_cs[2];
    assign w_last      = r_bit_cnt == 3'd7;
    assign w_start     = (r_state == IDLE) && w_cs_fall && r_armed;
    assign miso        = (r_state == RDATA) & r_tx[7];
    assign read        = r_state == RREQ;
    assign write       = r_write;
    assign addr        = r_addr;
    assign data_write  = r_data_write;
    assign frame_err   = w_abort;
    // Synchronize SPI pins; arm frame start only once cs_n has been genuinely seen high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk  <= 3'b000;
            r_cs    <= 3'b111;
            r_mosi  <= 2'b00;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sclk  <= {r_sclk[1:0], sclk};
            r_cs    <= {r_cs[1:0], cs_n};
            r_mosi  <= {r_mosi[0], mosi};
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & r_cs[1]);
        end
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Next-state logic; cs_n rising mid-frame aborts with an error pulse
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE:    w_next = w_start ? CMD : IDLE;
            CMD:     if (w_sclk_rise && w_last) w_next = r_rx[6] ? WDATA : RREQ;
            WDATA:   if (w_sclk_rise && w_last) w_next = DONE;
            RREQ:    w_next = RCAP;
            RCAP:    w_next = RDATA;
            RDATA:   if (w_sclk_rise && w_last) w_next = DONE;
            DONE:    if (w_cs_rise) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_cs_rise && (r_state inside {CMD, WDATA, RREQ, RCAP, RDATA})) begin
            w_next  = IDLE;
            w_abort = 1'b1;
        end
    end
    // Shift registers, bit counter, captured address/data and the write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 3'd0;
            r_rx         <= 7'd0;
            r_tx         <= 8'd0;
            r_addr       <= 6'd0;
            r_data_write <= 8'd0;
            r_write      <= 1'b0;
        end else begin
            r_write <= 1'b0;
            if (w_start) begin
                r_bit_cnt <= 3'd0;
                r_rx      <= 7'd0;
            end else if (!w_abort && w_sclk_rise && (r_state inside {CMD, WDATA, RDATA})) begin
                r_rx      <= {r_rx[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_last && r_state == CMD) r_addr <= {r_rx[4:0], w_mosi};
                if (w_last && r_state == WDATA) begin
                    r_data_write <= {r_rx, w_mosi};
                    r_write      <= 1'b1;
                end
            end
            if (r_state == RCAP) r_tx <= data_read;
            else if (!w_abort && r_state == RDATA && w_sclk_fall && r_bit_cnt != 3'd0) r_tx <= {r_tx[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: scoreboard bench driving SPI frames and checking strobes, miso and frame errors
module tb_spi_reg_bridge;
    localparam int H = 10;
    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, read, write, frame_err;
    logic [5:0] addr;
    logic [7:0] data_write, data_read = 8'h00;
    int         checks = 0, failures = 0, err_exp = 0;
    logic [13:0] wq[$];
    logic [5:0]  rq[$];
    logic [13:0] e_w;
    logic [5:0]  e_r;
    logic [7:0]  rx;
    logic        bad;

    spi_reg_bridge dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .read(read), .write(write), .addr(addr), .data_write(data_write),
        .data_read(data_read), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe and error pulse must match a pending expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (write) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected got addr=%h data=%h expected no write", addr, data_write);
                end else begin
                    e_w = wq.pop_front();
                    if ({addr, data_write} !== e_w) begin
                        failures++;
                        $display("FAIL write_value got addr=%h data=%h expected addr=%h data=%h", addr, data_write, e_w[13:8], e_w[7:0]);
                    end
                end
            end
            if (read) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL read_unexpected got addr=%h expected no read", addr);
                end else begin
                    e_r = rq.pop_front();
                    if (addr !== e_r) begin
                        failures++;
                        $display("FAIL read_addr got %h expected %h", addr, e_r);
                    end
                end
            end
            if (read && write) begin
                checks++;
                failures++;
                $display("FAIL read_write_overlap got read=1 write=1 expected at most one");
            end
            if (frame_err) begin
                checks++;
                if (err_exp == 0) begin
                    failures++;
                    $display("FAIL frame_err_unexpected got 1 expected 0");
                end else err_exp--;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] tx, input int nbits, output logic [7:0] rxb, output logic miso_bad);
        rxb = 8'h00;
        miso_bad = 1'b0;
        cs_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? tx[15-i] : 1'($urandom_range(0, 1));
            wait_clk(H);
            if (i >= 8 && i < 16) rxb = {rxb[6:0], miso};
            else if (miso !== 1'b0) miso_bad = 1'b1;
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        wait_clk(H);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_reset;
        wait_clk(3);
        checks++;
        if ({miso, read, write, addr, data_write, frame_err} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h expected 0", {miso, read, write, addr, data_write, frame_err});
        end
        rst_n = 1'b1;
        wait_clk(6);
        checks++;
        if ({miso, read, write, addr, data_write, frame_err} !== 18'd0) begin
            failures++;
            $display("FAIL post_reset_idle got %h expected 0", {miso, read, write, addr, data_write, frame_err});
        end
    endtask

    task automatic test_write;
        wq.push_back({6'h00, 8'h34});
        xfer(16'h8034, 16, rx, bad);
        checks++;
        if (bad !== 1'b0 || rx !== 8'h00) begin
            failures++;
            $display("FAIL write_miso_quiet got cmdbits_bad=%b databits=%h expected 0/00", bad, rx);
        end
        wait_clk(20);
        checks++;
        if (addr !== 6'h00 || data_write !== 8'h34) begin
            failures++;
            $display("FAIL write_hold got addr=%h data=%h expected 00/34", addr, data_write);
        end
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || err_exp != 0) begin
            failures++;
            $display("FAIL write_pending got wq=%0d rq=%0d err=%0d expected 0/0/0", wq.size(), rq.size(), err_exp);
        end
    endtask

    task automatic test_read;
        data_read = 8'hAB;
        rq.push_back(6'h09);
        xfer(16'h0900, 16, rx, bad);
        checks++;
        if (rx !== 8'hAB || bad !== 1'b0) begin
            failures++;
            $display("FAIL read_miso_ab got %h bad=%b expected ab bad=0", rx, bad);
        end
        data_read = 8'h5C;
        rq.push_back(6'h3F);
        xfer(16'h7F00, 16, rx, bad);
        checks++;
        if (rx !== 8'h5C || bad !== 1'b0) begin
            failures++;
            $display("FAIL read_miso_5c got %h bad=%b expected 5c bad=0", rx, bad);
        end
        wait_clk(20);
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || err_exp != 0 || addr !== 6'h3F) begin
            failures++;
            $display("FAIL read_pending got wq=%0d rq=%0d err=%0d addr=%h expected 0/0/0/3f", wq.size(), rq.size(), err_exp, addr);
        end
    endtask

    task automatic test_reserved;
        wq.push_back({6'h01, 8'h12});
        xfer(16'hC112, 16, rx, bad);
        wait_clk(20);
        checks++;
        if (wq.size() != 0 || err_exp != 0 || addr !== 6'h01 || data_write !== 8'h12) begin
            failures++;
            $display("FAIL reserved_bit got wq=%0d err=%0d addr=%h data=%h expected 0/0/01/12", wq.size(), err_exp, addr, data_write);
        end
    endtask

    task automatic test_abort;
        err_exp++;
        xfer(16'h8A77, 5, rx, bad);
        wait_clk(10);
        checks++;
        if (err_exp != 0) begin
            failures++;
            $display("FAIL abort_cmd got pending_err=%0d expected 0", err_exp);
        end
        err_exp++;
        xfer(16'h8A77, 12, rx, bad);
        wait_clk(10);
        checks++;
        if (err_exp != 0 || data_write !== 8'h12) begin
            failures++;
            $display("FAIL abort_wdata got pending_err=%0d data=%h expected 0/12", err_exp, data_write);
        end
        data_read = 8'hFF;
        rq.push_back(6'h2A);
        err_exp++;
        xfer(16'h2A00, 12, rx, bad);
        wait_clk(10);
        checks++;
        if (err_exp != 0 || rq.size() != 0 || miso !== 1'b0) begin
            failures++;
            $display("FAIL abort_rdata got pending_err=%0d rq=%0d miso=%b expected 0/0/0", err_exp, rq.size(), miso);
        end
        wq.push_back({6'h15, 8'h3C});
        xfer(16'h953C, 16, rx, bad);
        wait_clk(20);
        checks++;
        if (wq.size() != 0 || err_exp != 0) begin
            failures++;
            $display("FAIL abort_recover got wq=%0d err=%0d expected 0/0", wq.size(), err_exp);
        end
    endtask

    task automatic test_back_to_back;
        wq.push_back({6'h07, 8'h11});
        wq.push_back({6'h08, 8'h22});
        xfer(16'h8711, 16, rx, bad);
        xfer(16'h8822, 20, rx, bad);
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL b2b_miso_quiet got bad=%b expected 0", bad);
        end
        wait_clk(20);
        checks++;
        if (wq.size() != 0 || err_exp != 0 || data_write !== 8'h22) begin
            failures++;
            $display("FAIL b2b_pending got wq=%0d err=%0d data=%h expected 0/0/22", wq.size(), err_exp, data_write);
        end
    endtask

    task automatic test_reset_mid_frame;
        cs_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 16; i++) begin
            if (i == 11) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({miso, read, write, addr, data_write, frame_err} !== 18'd0) begin
                    failures++;
                    $display("FAIL reset_mid_frame got %h expected 0", {miso, read, write, addr, data_write, frame_err});
                end
                wait_clk(3);
                rst_n = 1'b1;
            end
            mosi = (i < 8) ? 1'b1 : 1'b0;
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        wait_clk(H);
        cs_n = 1'b1;
        wait_clk(20);
        checks++;
        if (addr !== 6'h00 || data_write !== 8'h00 || wq.size() != 0 || err_exp != 0) begin
            failures++;
            $display("FAIL reset_ignore_frame got addr=%h data=%h expected 00/00", addr, data_write);
        end
        wq.push_back({6'h05, 8'h5A});
        xfer(16'h855A, 16, rx, bad);
        wait_clk(20);
        checks++;
        if (wq.size() != 0 || addr !== 6'h05 || data_write !== 8'h5A) begin
            failures++;
            $display("FAIL reset_recover got wq=%0d addr=%h data=%h expected 0/05/5a", wq.size(), addr, data_write);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_reserved;
        test_abort;
        test_back_to_back;
        test_reset_mid_frame;
        wait_clk(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
